// File: rtl/dice_pkg.sv
// rtl/dice_pkg.sv - shared glyphs, blink state and default timing for the dice display
package dice_pkg;

  localparam logic [6:0] SEG_0     = 7'b0111111;
  localparam logic [6:0] SEG_1     = 7'b0000110;
  localparam logic [6:0] SEG_2     = 7'b1011011;
  localparam logic [6:0] SEG_3     = 7'b1001111;
  localparam logic [6:0] SEG_4     = 7'b1100110;
  localparam logic [6:0] SEG_5     = 7'b1101101;
  localparam logic [6:0] SEG_6     = 7'b1111101;
  localparam logic [6:0] SEG_7     = 7'b0000111;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1101111;
  localparam logic [6:0] SEG_E     = 7'b1111001;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  typedef enum logic {
    IDLE  = 1'b0,
    BLINK = 1'b1
  } blink_state_e;

  localparam int REFRESH_DIV_BITS_DEF = 5;
  localparam int BLINK_DIV_BITS_DEF   = 13;
  localparam int BLINK_COUNT_DEF      = 3;

endpackage

// File: rtl/bcd_to_seg7.sv
// rtl/bcd_to_seg7.sv - combinational BCD code to 7-segment glyph, non-BCD codes show E
module bcd_to_seg7
  import dice_pkg::*;
(
  input  logic [3:0] code_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_E;
    case (code_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_E;
    endcase
  end

endmodule

// File: rtl/dice_display_driver.sv
// rtl/dice_display_driver.sv - captures a two-digit BCD roll and drives a muxed 7-seg display with a blink burst
module dice_display_driver
  import dice_pkg::*;
#(
  parameter int REFRESH_DIV_BITS = REFRESH_DIV_BITS_DEF,
  parameter int BLINK_DIV_BITS   = BLINK_DIV_BITS_DEF,
  parameter int BLINK_COUNT      = BLINK_COUNT_DEF
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       bcd_valid_i,
  input  logic [3:0] bcd_tens_i,
  input  logic [3:0] bcd_ones_i,
  input  logic       blank_lz_i,
  output logic [6:0] seg_o,
  output logic [1:0] dig_en_o,
  output logic       busy_o
);

  localparam int H_W = $clog2(2 * BLINK_COUNT);
  localparam logic [H_W-1:0] H_LAST = H_W'(2 * BLINK_COUNT - 1);

  logic [3:0]                  tens_q, ones_q;
  logic                        err_q;
  logic [REFRESH_DIV_BITS-1:0] refresh_q;
  blink_state_e                state_q;
  logic [BLINK_DIV_BITS-1:0]   timer_q;
  logic [H_W-1:0]              h_q;
  logic [6:0]                  seg_q, seg_d;
  logic [1:0]                  dig_en_q, dig_en_d;
  logic                        busy_q, busy_d;

  logic       tens_slot;
  logic [3:0] code;
  logic [6:0] glyph;
  logic       dark;

  assign tens_slot = refresh_q[REFRESH_DIV_BITS-1];
  // An error forces E into the ones slot; the tens slot is blanked below.
  assign code = err_q ? 4'hE : (tens_slot ? tens_q : ones_q);

  bcd_to_seg7 u_bcd_to_seg7 (
    .code_i (code),
    .seg_o  (glyph)
  );

  always_comb begin
    dark     = 1'b0;
    seg_d    = SEG_BLANK;
    dig_en_d = 2'b00;
    busy_d   = (state_q == BLINK);
    dark     = ((state_q == BLINK) && h_q[0]) ||
               (tens_slot && (err_q || (blank_lz_i && (tens_q == 4'd0))));
    if (!dark) begin
      seg_d    = glyph;
      dig_en_d = tens_slot ? 2'b10 : 2'b01;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tens_q    <= 4'd0;
      ones_q    <= 4'd0;
      err_q     <= 1'b0;
      refresh_q <= '0;
      state_q   <= IDLE;
      timer_q   <= '0;
      h_q       <= '0;
      seg_q     <= SEG_BLANK;
      dig_en_q  <= 2'b00;
      busy_q    <= 1'b0;
    end else begin
      refresh_q <= refresh_q + REFRESH_DIV_BITS'(1);
      seg_q     <= seg_d;
      dig_en_q  <= dig_en_d;
      busy_q    <= busy_d;
      if (bcd_valid_i) begin
        tens_q  <= bcd_tens_i;
        ones_q  <= bcd_ones_i;
        err_q   <= (bcd_tens_i > 4'd9) || (bcd_ones_i > 4'd9);
        state_q <= BLINK;
        timer_q <= '0;
        h_q     <= '0;
      end else if (state_q == BLINK) begin
        timer_q <= timer_q + BLINK_DIV_BITS'(1);
        if (timer_q == '1) begin
          if (h_q == H_LAST) begin
            state_q <= IDLE;
          end else begin
            h_q <= h_q + H_W'(1);
          end
        end
      end
    end
  end

  assign seg_o    = seg_q;
  assign dig_en_o = dig_en_q;
  assign busy_o   = busy_q;

endmodule

// File: tb/tb_dice_display_driver.sv
// tb/tb_dice_display_driver.sv - randomized scoreboard bench for dice_display_driver
module tb_dice_display_driver;

  localparam int RB    = 2;
  localparam int BB    = 3;
  localparam int BC    = 2;
  localparam int SLOTP = 1 << RB;
  localparam int HALF  = 1 << BB;
  localparam int BURST = 2 * BC * HALF;
  localparam int BIG   = 1000000;

  typedef struct packed {
    logic [6:0] seg;
    logic [1:0] en;
    logic       busy;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       bcd_valid;
  logic [3:0] bcd_tens, bcd_ones;
  logic       blank_lz;
  logic [6:0] seg;
  logic [1:0] dig_en;
  logic       busy;

  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;
  exp_t exp_q[$];

  logic [6:0] glyph_tab [0:9];

  dice_display_driver #(
    .REFRESH_DIV_BITS (RB),
    .BLINK_DIV_BITS   (BB),
    .BLINK_COUNT      (BC)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .bcd_valid_i (bcd_valid),
    .bcd_tens_i  (bcd_tens),
    .bcd_ones_i  (bcd_ones),
    .blank_lz_i  (blank_lz),
    .seg_o       (seg),
    .dig_en_o    (dig_en),
    .busy_o      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: time since reset gives slot, time since capture gives blink phase.
  int         m_ph    = 0;
  int         m_since = BIG;
  logic [3:0] m_tens  = 4'd0;
  logic [3:0] m_ones  = 4'd0;
  bit         m_err   = 1'b0;
  bit         m_tslot, m_dark;
  exp_t       m_e;

  initial begin
    forever begin
      @(posedge clk);
      m_e = '0;
      if (!rst) begin
        m_tslot = (m_ph % SLOTP) >= (SLOTP / 2);
        m_dark  = (m_since < BURST) && (((m_since / HALF) % 2) == 1);
        m_e.busy = (m_since < BURST);
        if (m_tslot) begin
          if (m_err || (blank_lz && m_tens == 4'd0)) m_dark = 1'b1;
          else m_e.seg = glyph_tab[m_tens];
        end else begin
          m_e.seg = m_err ? 7'b1111001 : glyph_tab[m_ones];
        end
        if (m_dark) m_e.seg = 7'd0;
        else m_e.en = m_tslot ? 2'b10 : 2'b01;
      end
      exp_q.push_back(m_e);
      if (rst) begin
        m_ph = 0; m_since = BIG; m_tens = 0; m_ones = 0; m_err = 0;
      end else begin
        m_ph++;
        if (bcd_valid) begin
          m_tens  = bcd_tens;
          m_ones  = bcd_ones;
          m_err   = (bcd_tens > 9) || (bcd_ones > 9);
          m_since = 0;
        end else if (m_since < BIG) begin
          m_since++;
        end
      end
    end
  end

  exp_t mon_e;
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        checks++;
        if ({seg, dig_en, busy} !== mon_e) begin
          errors++;
          $display("FAIL out cyc=%0d seg=%b exp=%b dig_en=%b exp=%b busy=%b exp=%b",
                   cyc, seg, mon_e.seg, dig_en, mon_e.en, busy, mon_e.busy);
        end
        checks++;
        if (dig_en == 2'b00 && seg !== 7'd0) begin
          errors++;
          $display("FAIL dark_seg cyc=%0d seg=%b required 0000000 with dig_en=00", cyc, seg);
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic capture(input logic [3:0] t, input logic [3:0] o, input int hold);
    bcd_valid = 1'b1;
    bcd_tens  = t;
    bcd_ones  = o;
    repeat (hold) tick();
    bcd_valid = 1'b0;
  endtask

  task automatic measure_busy(input int want);
    int n;
    bit done;
    n = 0;
    done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      tick();
      if (busy) n++;
      else if (n > 0) done = 1'b1;
    end
    checks++;
    if (!done || n != want) begin
      errors++;
      $display("FAIL busy_width got=%0d required=%0d done=%0d", n, want, done);
    end
  endtask

  initial begin
    glyph_tab[0] = 7'b0111111; glyph_tab[1] = 7'b0000110;
    glyph_tab[2] = 7'b1011011; glyph_tab[3] = 7'b1001111;
    glyph_tab[4] = 7'b1100110; glyph_tab[5] = 7'b1101101;
    glyph_tab[6] = 7'b1111101; glyph_tab[7] = 7'b0000111;
    glyph_tab[8] = 7'b1111111; glyph_tab[9] = 7'b1101111;
    rst = 1'b1; bcd_valid = 1'b0; bcd_tens = 4'd0; bcd_ones = 4'd0; blank_lz = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    repeat (8) tick();

    capture(4'd4, 4'd2, 1);
    measure_busy(BURST);
    repeat (8) tick();

    blank_lz = 1'b1;
    capture(4'd0, 4'd6, 1);
    repeat (40) tick();
    blank_lz = 1'b0;

    capture(4'hA, 4'd3, 1);
    repeat (40) tick();

    capture(4'd1, 4'd2, 1);
    repeat (11) tick();
    capture(4'd2, 4'd0, 1);
    repeat (40) tick();

    capture(4'd5, 4'd5, 1);
    repeat (9) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (40) tick();

    for (int i = 0; i < 40; i++) begin
      blank_lz = 1'($urandom_range(0, 1));
      capture(($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9)),
              ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9)),
              $urandom_range(1, 2));
      repeat ($urandom_range(1, 40)) tick();
      if ($urandom_range(0, 12) == 0) begin
        rst = 1'b1;
        repeat ($urandom_range(1, 2)) tick();
        rst = 1'b0;
      end
    end

    repeat (40) tick();
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
